// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, the bubble instruction and fetch FSM states shared by the fetch stage
package cpu_pkg;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_BGT  = 4'b0101;
  localparam logic [3:0] OP_BLT  = 4'b0110;
  localparam logic [3:0] OP_B    = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [31:0] NOP_INSTR = {OP_NOP, 28'd0};
  typedef enum logic [1:0] {START, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch stage <-> instruction RAM, hazard/control unit and decode
interface fetch_stage_if #(parameter int PC_W = 16, parameter int INSTR_W = 32);
  logic               stall;
  logic               flagN;
  logic               flagZ;
  logic               ni;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;
  logic               if_id_valid;
  logic               halted;
  modport master (
    input  stall, flagN, flagZ, ni, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid, halted
  );
  modport slave (
    output stall, flagN, flagZ, ni, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid, halted
  );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: decides beq/bgt/blt/b in ID and computes the word-offset target
module branch_resolve import cpu_pkg::*; #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 12
) (
  input  logic [3:0]      opcode,
  input  logic            valid,
  input  logic            flagN,
  input  logic            flagZ,
  input  logic [PC_W-1:0] pc,
  input  logic [IMM_W-1:0] imm,
  output logic            taken,
  output logic [PC_W-1:0] target
);
  logic [PC_W+IMM_W-1:0] w_sext;
  assign w_sext = {{PC_W{imm[IMM_W-1]}}, imm};
  assign target = pc + w_sext[PC_W-1:0];
  assign taken  = valid && ((opcode == OP_B) ||
                            (opcode == OP_BEQ && flagZ) ||
                            (opcode == OP_BGT && !flagN && !flagZ) ||
                            (opcode == OP_BLT && flagN));
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, branch resolution in ID and the IF/ID register; freezes on halt.
// Define FETCH_PERF_EN to add saturating fetch/flush performance counters.
module fetch_stage import cpu_pkg::*; #(
  parameter int PC_W     = 16,
  parameter int INSTR_W  = 32,
  parameter int IMM_W    = 12,
  parameter int RESET_PC = 0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);
  localparam logic [INSTR_W-1:0] L_NOP = {OP_NOP, {(INSTR_W-4){1'b0}}};
  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_target;
  logic            w_taken, w_run, w_halt_go, w_br, w_adv;
  branch_resolve #(.PC_W(PC_W), .IMM_W(IMM_W)) u_br (
    .opcode (bus.if_id_instr[INSTR_W-1 -: 4]),
    .valid  (bus.if_id_valid),
    .flagN  (bus.flagN),
    .flagZ  (bus.flagZ),
    .pc     (bus.if_id_pc),
    .imm    (bus.if_id_instr[IMM_W-1:0]),
    .taken  (w_taken),
    .target (w_target)
  );
  assign w_run     = r_state == RUN;
  assign w_halt_go = w_run && !bus.ni && bus.if_id_valid;
  assign w_br      = w_run && !w_halt_go && !bus.stall && w_taken;
  assign w_adv     = w_run && !w_halt_go && !bus.stall && !w_taken;
  // r_pc is the address of the word currently on imem_rdata
  assign bus.imem_addr = w_br ? w_target : w_adv ? r_pc + 1'b1 : r_pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state         <= START;
      r_pc            <= PC_W'(RESET_PC);
      bus.if_id_instr <= L_NOP;
      bus.if_id_pc    <= '0;
      bus.if_id_valid <= 1'b0;
      bus.halted      <= 1'b0;
    end else if (r_state == START) begin
      r_state         <= RUN;
      bus.if_id_instr <= L_NOP;
      bus.if_id_valid <= 1'b0;
    end else if (w_halt_go) begin
      r_state         <= HALT;
      bus.halted      <= 1'b1;
    end else if (w_br) begin
      r_pc            <= w_target;
      bus.if_id_instr <= L_NOP;
      bus.if_id_valid <= 1'b0;
    end else if (w_adv) begin
      r_pc            <= r_pc + 1'b1;
      bus.if_id_instr <= bus.imem_rdata;
      bus.if_id_pc    <= r_pc;
      bus.if_id_valid <= 1'b1;
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (w_adv && !(&perf_fetch_cnt)) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (w_br && !(&perf_flush_cnt)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run against an ISA-level fetch model
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem [65536];
  logic [31:0] mem4 [16];
  localparam logic [31:0] NOP = 32'hD000_0000;

  fetch_stage_if #(.PC_W(16), .INSTR_W(32)) bif ();
  fetch_stage_if #(.PC_W(4), .INSTR_W(32)) bif4 ();
`ifdef FETCH_PERF_EN
  logic [31:0] pf, pfl, pf4, pfl4;
`endif

  fetch_stage #(.PC_W(16), .INSTR_W(32), .IMM_W(12), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(pf), .perf_flush_cnt(pfl)
`endif
  );
  fetch_stage #(.PC_W(4), .INSTR_W(32), .IMM_W(12), .RESET_PC(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bif4)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(pf4), .perf_flush_cnt(pfl4)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) bif.imem_rdata <= mem[bif.imem_addr];
  always @(posedge clk) bif4.imem_rdata <= mem4[bif4.imem_addr];
  // control unit: only the halt opcode deasserts ni
  assign bif.ni  = bif.if_id_instr[31:28] != 4'hF;
  assign bif4.ni = bif4.if_id_instr[31:28] != 4'hF;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [11:0] imm);
    logic [15:0] mid;
    mid = 16'($urandom);
    return {op, mid, imm};
  endfunction

  function automatic bit br_taken(input logic [31:0] ins, input bit n, input bit z);
    logic [3:0] op;
    op = ins[31:28];
    return (op == 4'h4 && z) || (op == 4'h5 && !n && !z) || (op == 4'h6 && n) || (op == 4'h7);
  endfunction

  task automatic straight(input int n);
    for (int i = 0; i < n; i++) mem[i] = mk(4'($urandom_range(0, 3)), 12'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bif.stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk += 5;
    if (bif.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bif.if_id_valid); end
    if (bif.if_id_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", bif.if_id_instr, NOP); end
    if (bif.if_id_pc !== 16'd0) begin n_fail++; $display("FAIL reset_pc got %0d want 0", bif.if_id_pc); end
    if (bif.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", bif.halted); end
    if (bif.imem_addr !== 16'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bif.imem_addr); end
  endtask

  task automatic test_straight();
    mem[0] = mk(4'h0, 12'h011);
    mem[1] = mk(4'h1, 12'h022);
    mem[2] = mk(4'h2, 12'h033);
    mem[3] = mk(4'h3, 12'h044);
    do_reset();
    n_chk++;
    if (bif.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL start_bubble valid got %b want 0", bif.if_id_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk += 3;
      if (bif.if_id_pc !== 16'(i)) begin n_fail++; $display("FAIL straight_pc got %0d want %0d", bif.if_id_pc, i); end
      if (bif.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL straight_valid got %b want 1", bif.if_id_valid); end
      if (bif.if_id_instr !== mem[i]) begin n_fail++; $display("FAIL straight_instr got %h want %h", bif.if_id_instr, mem[i]); end
    end
  endtask

  task automatic test_beq();
    for (int z = 0; z < 2; z++) begin
      straight(4);
      mem[4] = mk(4'h4, 12'd6);
      mem[5] = mk(4'h0, 12'd0);
      mem[6] = mk(4'h0, 12'd0);
      mem[10] = mk(4'h1, 12'd0);
      bif.flagZ = z[0];
      bif.flagN = 1'($urandom);
      do_reset();
      repeat (5) @(negedge clk);
      n_chk++;
      if (bif.if_id_pc !== 16'd4) begin n_fail++; $display("FAIL beq_at_pc got %0d want 4", bif.if_id_pc); end
      @(negedge clk);
      n_chk++;
      if (bif.if_id_valid !== !z[0]) begin n_fail++; $display("FAIL beq_flush z=%0d valid got %b want %b", z, bif.if_id_valid, !z[0]); end
      @(negedge clk);
      n_chk += 2;
      if (bif.if_id_pc !== (z ? 16'd10 : 16'd6)) begin n_fail++; $display("FAIL beq_next z=%0d pc got %0d want %0d", z, bif.if_id_pc, z ? 10 : 6); end
      if (bif.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL beq_next_valid got %b want 1", bif.if_id_valid); end
    end
  endtask

  task automatic test_cond();
    bit tk;
    for (int o = 5; o < 7; o++)
      for (int nz = 0; nz < 3; nz++) begin
        mem[0] = mk(4'(o), 12'd5);
        mem[1] = mk(4'h0, 12'd0);
        mem[2] = mk(4'h0, 12'd0);
        mem[5] = mk(4'h1, 12'd0);
        bif.flagN = nz[1];
        bif.flagZ = nz[0];
        tk = (o == 5) ? (nz == 0) : nz[1];
        do_reset();
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (bif.if_id_valid !== !tk) begin n_fail++; $display("FAIL cond op=%0d nz=%0d valid got %b want %b", o, nz, bif.if_id_valid, !tk); end
        @(negedge clk);
        n_chk++;
        if (bif.if_id_pc !== (tk ? 16'd5 : 16'd2)) begin n_fail++; $display("FAIL cond_pc op=%0d nz=%0d got %0d want %0d", o, nz, bif.if_id_pc, tk ? 5 : 2); end
      end
    straight(8);
    mem[8] = mk(4'h7, 12'hFFC);
    do_reset();
    repeat (9) @(negedge clk);
    n_chk++;
    if (bif.if_id_pc !== 16'd8) begin n_fail++; $display("FAIL b_at_pc got %0d want 8", bif.if_id_pc); end
    @(negedge clk);
    n_chk++;
    if (bif.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL b_flush valid got %b want 0", bif.if_id_valid); end
    @(negedge clk);
    n_chk++;
    if (bif.if_id_pc !== 16'd4) begin n_fail++; $display("FAIL b_target got %0d want 4", bif.if_id_pc); end
  endtask

  task automatic test_stall();
    logic [15:0] a0;
    straight(2);
    mem[2] = mk(4'h4, 12'd3);
    mem[3] = mk(4'h0, 12'd0);
    mem[5] = mk(4'h2, 12'd0);
    bif.flagZ = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    bif.stall = 1'b1;
    #1 a0 = bif.imem_addr;
    repeat (3) begin
      @(negedge clk);
      n_chk += 3;
      if (bif.if_id_pc !== 16'd2) begin n_fail++; $display("FAIL stall_pc got %0d want 2", bif.if_id_pc); end
      if (bif.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b want 1", bif.if_id_valid); end
      if (bif.imem_addr !== a0) begin n_fail++; $display("FAIL stall_addr got %0d want %0d", bif.imem_addr, a0); end
    end
    bif.stall = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bif.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL stall_resolve valid got %b want 0", bif.if_id_valid); end
    @(negedge clk);
    n_chk++;
    if (bif.if_id_pc !== 16'd5) begin n_fail++; $display("FAIL stall_target got %0d want 5", bif.if_id_pc); end
  endtask

  task automatic test_halt();
    logic [15:0] a0;
    straight(7);
    mem[7] = mk(4'hF, 12'd0);
    do_reset();
    repeat (8) @(negedge clk);
    n_chk++;
    if (bif.halted !== 1'b0) begin n_fail++; $display("FAIL halt_early got %b want 0", bif.halted); end
    @(negedge clk);
    n_chk += 2;
    if (bif.halted !== 1'b1) begin n_fail++; $display("FAIL halt_set got %b want 1", bif.halted); end
    if (bif.if_id_pc !== 16'd7) begin n_fail++; $display("FAIL halt_pc got %0d want 7", bif.if_id_pc); end
    a0 = bif.imem_addr;
    for (int i = 0; i < 20; i++) begin
      bif.stall = ~bif.stall;
      bif.flagN = 1'($urandom);
      bif.flagZ = 1'($urandom);
      @(negedge clk);
      n_chk += 4;
      if (bif.halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold got %b want 1", bif.halted); end
      if (bif.if_id_pc !== 16'd7) begin n_fail++; $display("FAIL halt_frozen_pc got %0d want 7", bif.if_id_pc); end
      if (bif.if_id_instr !== mem[7]) begin n_fail++; $display("FAIL halt_frozen_instr got %h want %h", bif.if_id_instr, mem[7]); end
      if (bif.imem_addr !== a0) begin n_fail++; $display("FAIL halt_addr got %0d want %0d", bif.imem_addr, a0); end
    end
    bif.stall = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk += 2;
    if (bif.halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset got %b want 0", bif.halted); end
    if (bif.imem_addr !== 16'd0) begin n_fail++; $display("FAIL halt_reset_addr got %0d want 0", bif.imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (bif.if_id_pc !== 16'd0 || bif.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL halt_restart pc/valid got %0d/%b want 0/1", bif.if_id_pc, bif.if_id_valid); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) mem4[i] = mk(4'($urandom_range(0, 3)), 12'($urandom));
    bif4.stall = 1'b0;
    bif4.flagN = 1'b0;
    bif4.flagZ = 1'b0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_chk += 2;
      if (bif4.if_id_pc !== 4'(k)) begin n_fail++; $display("FAIL wrap_pc got %0d want %0d", bif4.if_id_pc, k % 16); end
      if (bif4.if_id_instr !== mem4[k % 16]) begin n_fail++; $display("FAIL wrap_instr got %h want %h", bif4.if_id_instr, mem4[k % 16]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] e_pc, e_next;
    logic [31:0] e_instr;
    bit e_valid;
    int loads, flushes;
    for (int i = 0; i < 65536; i++) mem[i] = mk(4'($urandom_range(0, 14)), 12'($urandom));
    do_reset();
    e_pc = 0; e_next = 0; e_instr = NOP; e_valid = 0; loads = 0; flushes = 0;
    n_chk++;
    if (bif.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rand_bubble got %b want 0", bif.if_id_valid); end
    for (int c = 0; c < 400; c++) begin
      bif.stall = ($urandom_range(0, 3) == 0);
      bif.flagN = 1'($urandom);
      bif.flagZ = 1'($urandom);
      if (!bif.stall) begin
        if (e_valid && br_taken(e_instr, bif.flagN, bif.flagZ)) begin
          e_next = e_pc + {{4{e_instr[11]}}, e_instr[11:0]};
          e_valid = 0;
          e_instr = NOP;
          flushes++;
        end else begin
          e_pc = e_next;
          e_instr = mem[e_pc];
          e_valid = 1;
          e_next = e_pc + 16'd1;
          loads++;
        end
      end
      @(negedge clk);
      n_chk += 2;
      if (bif.if_id_valid !== e_valid) begin n_fail++; $display("FAIL rand_valid cyc=%0d got %b want %b", c, bif.if_id_valid, e_valid); end
      if (bif.if_id_instr !== e_instr) begin n_fail++; $display("FAIL rand_instr cyc=%0d got %h want %h", c, bif.if_id_instr, e_instr); end
      if (e_valid) begin
        n_chk++;
        if (bif.if_id_pc !== e_pc) begin n_fail++; $display("FAIL rand_pc cyc=%0d got %0d want %0d", c, bif.if_id_pc, e_pc); end
      end
    end
    bif.stall = 1'b0;
`ifdef FETCH_PERF_EN
    n_chk += 2;
    if (pf !== 32'(loads)) begin n_fail++; $display("FAIL perf_fetch got %0d want %0d", pf, loads); end
    if (pfl !== 32'(flushes)) begin n_fail++; $display("FAIL perf_flush got %0d want %0d", pfl, flushes); end
`endif
  endtask

  initial begin
    bif.stall = 1'b0; bif.flagN = 1'b0; bif.flagZ = 1'b0;
    bif4.stall = 1'b0; bif4.flagN = 1'b0; bif4.flagZ = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = mk(4'h0, 12'd0);
    for (int i = 0; i < 16; i++) mem4[i] = mk(4'h0, 12'd0);
    test_reset();
    test_straight();
    test_beq();
    test_cond();
    test_stall();
    test_halt();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
